ad9783_spi_sequencer: RTL and testbench
=======================================

# ad9783_spi_sequencer

Power-up and run-time configuration controller for the AD9783 dual DAC. After reset it pulses the DAC hardware reset, waits for the part to settle, then writes a fixed table of register words over the 3-wire SPI port. Once that table is written, it accepts single-register writes from a host-side requester. It sits beside the AD9783 LVDS data driver and gates the sweep/servo datapath through `init_done_out`.

## Interface

- `CLK_DIV`, default 4: clk_in cycles per SCLK half-period (≥1).
- `RESET_CYCLES`, default 64: clk_in cycles `dac_reset_out` is held high.
- `RESET_WAIT`, default 1024: clk_in cycles from reset release to the first frame.
- `CS_GAP`, default 4: minimum clk_in cycles CS_n stays high between frames (≥1).
- `N_INIT`, default 4: number of entries in the init table.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous assert, active-low.
- `start_in` in 1: single-cycle pulse; reruns the full reset and init sequence.
- `wr_req_in` in 1: host write request (level).
- `wr_addr_in` in 5: register address.
- `wr_data_in` in 8: register data.
- `wr_ack_out` out 1: one-cycle pulse when a host frame is latched.
- `busy_out` out 1: high in every state except IDLE.
- `init_done_out` out 1: init table fully written.
- `dac_reset_out` out 1: AD9783 RESET pin, active-high.
- `spi_cs_n_out` out 1: SPI chip select, active-low.
- `spi_sclk_out` out 1: SPI clock, idles low.
- `spi_sdio_out` out 1: SPI data, MSB first.

## Operation

- Frame format: 16 bits, MSB first.
  - bit15 = 0 (write).
  - bits14:13 = 00 (one data byte).
  - bits12:8 = address.
  - bits7:0 = data.
- Reset values (while `rst_in` = 0):
  - `dac_reset_out` = 1, `spi_cs_n_out` = 1, `busy_out` = 1.
  - `spi_sclk_out`, `spi_sdio_out`, `wr_ack_out`, `init_done_out` = 0.
  - State = RST, all counters at 0.
- States:
  - RST: `dac_reset_out` = 1 for RESET_CYCLES cycles, then WAIT.
  - WAIT: `dac_reset_out` = 0 for RESET_WAIT cycles, then LOAD with index = 0.
  - LOAD (1 cycle, CS_n high): latch the frame from table[index], then SHIFT.
  - SHIFT: CS_n low for exactly 32·CLK_DIV cycles, then GAP.
  - GAP: CS_n high for CS_GAP cycles. Next state:
    - LOAD if index < N_INIT−1 (index increments);
    - otherwise IDLE, asserting `init_done_out`;
    - IDLE also after a host frame.
  - IDLE: `start_in` → RST (clears `init_done_out`). Else `wr_req_in` → latch `{3'b000, wr_addr_in, wr_data_in}`, pulse `wr_ack_out`, go to SHIFT.
- Host handshake:
  - Requester holds `wr_req_in` and address/data stable until it sees `wr_ack_out`.
  - Requests during RST through GAP stall without ack.
- `start_in` outside IDLE is ignored. If `start_in` and `wr_req_in` arrive in the same IDLE cycle, start wins and no ack is given.
- `rst_in` low mid-frame aborts immediately. CS_n returns high asynchronously and the sequence restarts from RST.

## Timing

- SHIFT, bit k = 15…0, one per 2·CLK_DIV cycles:
  - SDIO drives bit k for the whole period.
  - SCLK is low for the first CLK_DIV cycles, high for the second.
  - The DAC samples on the rising edge.
  - SDIO changes only while SCLK is low.
- The first SDIO bit is valid on the first SHIFT cycle. SCLK is low on the last SHIFT cycle before GAP is not required; SCLK falls as CS_n rises.
- All SPI outputs are registered; there is no combinational path from inputs.
- Init frame cost is 1 + 32·CLK_DIV + CS_GAP cycles.
- `init_done_out` rises exactly RESET_CYCLES + RESET_WAIT + N_INIT·(1 + 32·CLK_DIV + CS_GAP) cycles after `rst_in` deasserts.
- Host write:
  - `wr_ack_out` is high on the IDLE cycle that latches the frame.
  - CS_n falls on the next cycle.
  - `busy_out` is low again after 32·CLK_DIV + CS_GAP cycles.

## Structure

- Package `ad9783_pkg` holds:
  - the state enum (RST, WAIT, LOAD, SHIFT, GAP, IDLE);
  - the R/W and N-field constants;
  - the init table as a constant array of {addr[4:0], data[7:0]}.
- Default init table: (0x00, 0x00), (0x02, 0x00), (0x03, 0x00), (0x04, 0x00).
- Sub-module `spi_shift16`:
  - inputs: load pulse, 16-bit word;
  - outputs: SCLK, SDIO, done;
  - contains the half-period counter and bit counter.
- The top level contains the sequencer FSM, table index and host arbitration.

## Test plan

Bench parameters: CLK_DIV=2, RESET_CYCLES=8, RESET_WAIT=16, CS_GAP=4, N_INIT=4.

1. Reset release → `dac_reset_out` high for 8 cycles. Four frames 0x0000, 0x0200, 0x0300, 0x0400 are decoded on SCLK rising edges. `init_done_out` rises at cycle 8+16+4·69 = 300.
2. After init, hold `wr_req_in` with addr=0x0F, data=0xA5 → one `wr_ack_out` pulse. Frame decodes as 0x0FA5. `busy_out` is high for 68 cycles.
3. `wr_req_in` asserted from reset → no ack before `init_done_out`. Ack arrives in the first IDLE cycle.
4. `start_in` and `wr_req_in` together in IDLE → no ack, `init_done_out` drops, and the full sequence repeats. The request is then served.
5. `rst_in` pulsed low in the middle of frame 2 → CS_n goes high and SCLK goes low immediately. The restart re-emits all four frames.
6. SPI checker throughout: SDIO never toggles while SCLK is high. CS_n is high at least 4 cycles between frames.

Source files
------------

// File: rtl/ad9783_pkg.sv
// ad9783_pkg: sequencer states, SPI frame fields and the AD9783 power-up register table.
package ad9783_pkg;

    typedef enum logic [2:0] {ST_RST, ST_WAIT, ST_LOAD, ST_SHIFT, ST_GAP, ST_IDLE} state_t;

    localparam logic       RW_WRITE   = 1'b0;
    localparam logic [1:0] N_ONE_BYTE = 2'b00;

    // Entries are {addr[4:0], data[7:0]}
    localparam int          INIT_LEN = 4;
    localparam logic [12:0] INIT_TABLE [INIT_LEN] = '{13'h0000, 13'h0200, 13'h0300, 13'h0400};

    function automatic logic [15:0] spi_frame(input logic [4:0] addr, input logic [7:0] data);
        return {RW_WRITE, N_ONE_BYTE, addr, data};
    endfunction

endpackage

// File: rtl/spi_shift16.sv
// spi_shift16: shifts one 16-bit word out MSB first; SDIO moves only on the SCLK falling transition.
module spi_shift16 #(
    parameter int CLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [15:0] i_word,
    output logic        o_sclk,
    output logic        o_sdio,
    output logic        o_done
);

    logic [15:0] r_sh;
    logic [31:0] r_hcnt;
    logic [3:0]  r_bit;
    logic        r_active;
    logic        r_sclk;
    logic        w_half_end;

    assign w_half_end = r_active && (r_hcnt == CLK_DIV - 1);
    // Asserted during the final cycle of bit 0's high half; SCLK falls on the following edge
    assign o_done     = w_half_end && r_sclk && (r_bit == 4'd15);
    assign o_sclk     = r_sclk;
    assign o_sdio     = r_sh[15];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh     <= '0;
            r_hcnt   <= '0;
            r_bit    <= '0;
            r_active <= 1'b0;
            r_sclk   <= 1'b0;
        end else if (i_load) begin
            r_sh     <= i_word;
            r_hcnt   <= '0;
            r_bit    <= '0;
            r_active <= 1'b1;
            r_sclk   <= 1'b0;
        end else if (r_active) begin
            r_hcnt <= w_half_end ? '0 : r_hcnt + 32'd1;
            if (w_half_end) begin
                r_sclk <= !r_sclk;
                if (r_sclk) begin
                    r_sh  <= {r_sh[14:0], 1'b0};
                    r_bit <= r_bit + 4'd1;
                end
            end
            if (o_done)
                r_active <= 1'b0;
        end
    end

endmodule

// File: rtl/ad9783_spi_sequencer.sv
// ad9783_spi_sequencer: pulses the AD9783 reset, writes the init table over SPI, then serves host writes.
module ad9783_spi_sequencer
    import ad9783_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int RESET_CYCLES = 64,
    parameter int RESET_WAIT   = 1024,
    parameter int CS_GAP       = 4,
    parameter int N_INIT       = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_in,
    input  logic       wr_req_in,
    input  logic [4:0] wr_addr_in,
    input  logic [7:0] wr_data_in,
    output logic       wr_ack_out,
    output logic       busy_out,
    output logic       init_done_out,
    output logic       dac_reset_out,
    output logic       spi_cs_n_out,
    output logic       spi_sclk_out,
    output logic       spi_sdio_out
);

    state_t                        r_state;
    state_t                        w_next;
    logic [31:0]                   r_cnt;
    logic [$clog2(INIT_LEN)-1:0]   r_idx;
    logic                          r_init_done;
    logic                          r_cs_n;
    logic                          r_dac_rst;
    logic                          w_load;
    logic                          w_ack;
    logic                          w_done;
    logic [12:0]                   w_entry;
    logic [15:0]                   w_word;

    assign w_entry = INIT_TABLE[r_idx];
    assign w_word  = (r_state == ST_IDLE) ? spi_frame(wr_addr_in, wr_data_in)
                                          : spi_frame(w_entry[12:8], w_entry[7:0]);

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_ack  = 1'b0;
        case (r_state)
            ST_RST:   if (r_cnt == RESET_CYCLES - 1) w_next = ST_WAIT;
            ST_WAIT:  if (r_cnt == RESET_WAIT - 1) w_next = ST_LOAD;
            ST_LOAD: begin
                w_next = ST_SHIFT;
                w_load = 1'b1;
            end
            ST_SHIFT: if (w_done) w_next = ST_GAP;
            // Host frames only occur after init, so init_done tells the two GAP exits apart
            ST_GAP:   if (r_cnt == CS_GAP - 1)
                          w_next = (!r_init_done && (32'(r_idx) < N_INIT - 1)) ? ST_LOAD : ST_IDLE;
            ST_IDLE: begin
                if (start_in)
                    w_next = ST_RST;
                else if (wr_req_in) begin
                    w_next = ST_SHIFT;
                    w_load = 1'b1;
                    w_ack  = 1'b1;
                end
            end
            default:  w_next = ST_RST;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_init_done <= 1'b0;
            r_cs_n      <= 1'b1;
            r_dac_rst   <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_next != r_state) ? '0 : r_cnt + 32'd1;
            r_cs_n    <= (w_next != ST_SHIFT);
            r_dac_rst <= (w_next == ST_RST);
            if (r_state == ST_WAIT)
                r_idx <= '0;
            else if (r_state == ST_GAP && w_next == ST_LOAD)
                r_idx <= r_idx + 1'b1;
            if (w_next == ST_RST)
                r_init_done <= 1'b0;
            else if (r_state == ST_GAP && w_next == ST_IDLE)
                r_init_done <= 1'b1;
        end
    end

    spi_shift16 #(.CLK_DIV(CLK_DIV)) u_shift (
        .i_clk   (clk_in),
        .i_rst_n (rst_in),
        .i_load  (w_load),
        .i_word  (w_word),
        .o_sclk  (spi_sclk_out),
        .o_sdio  (spi_sdio_out),
        .o_done  (w_done)
    );

    assign wr_ack_out    = w_ack;
    assign busy_out      = (r_state != ST_IDLE);
    assign init_done_out = r_init_done;
    assign dac_reset_out = r_dac_rst;
    assign spi_cs_n_out  = r_cs_n;

endmodule

// File: tb/tb_ad9783_spi_sequencer.sv
// tb_ad9783_spi_sequencer: scenario tasks plus an SPI monitor that decodes frames against an expected queue.
module tb_ad9783_spi_sequencer;

    localparam int CLK_DIV      = 2;
    localparam int RESET_CYCLES = 8;
    localparam int RESET_WAIT   = 16;
    localparam int CS_GAP       = 4;
    localparam int N_INIT       = 4;
    localparam int INIT_CYC     = 300;
    localparam int HOST_BUSY    = 68;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       start_in = 1'b0;
    logic       wr_req_in = 1'b0;
    logic [4:0] wr_addr_in = '0;
    logic [7:0] wr_data_in = '0;
    logic       wr_ack_out, busy_out, init_done_out, dac_reset_out;
    logic       spi_cs_n_out, spi_sclk_out, spi_sdio_out;

    ad9783_spi_sequencer #(
        .CLK_DIV(CLK_DIV), .RESET_CYCLES(RESET_CYCLES), .RESET_WAIT(RESET_WAIT),
        .CS_GAP(CS_GAP), .N_INIT(N_INIT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .wr_req_in(wr_req_in),
        .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .wr_ack_out(wr_ack_out),
        .busy_out(busy_out), .init_done_out(init_done_out), .dac_reset_out(dac_reset_out),
        .spi_cs_n_out(spi_cs_n_out), .spi_sclk_out(spi_sclk_out), .spi_sdio_out(spi_sdio_out)
    );

    always #5 clk_in = ~clk_in;

    int          n_chk = 0;
    int          n_fail = 0;
    int          frames = 0;
    int          aborts = 0;
    logic [15:0] exp_q[$];

    // SPI monitor: decodes on SCLK rising edges, scores each frame when CS_n rises
    logic        p_cs_low = 1'b0, p_sclk = 1'b0, p_sdio = 1'b0;
    logic        hi_toggle = 1'b0, idle_sclk = 1'b0;
    logic [15:0] shreg = '0;
    logic [15:0] exp_w;
    int          bits = 0;
    int          gap = 100;

    always @(negedge clk_in) begin
        if (!spi_cs_n_out) begin
            if (!p_cs_low) begin
                n_chk++;
                if (gap < CS_GAP || idle_sclk) begin
                    n_fail++;
                    $display("FAIL cs_gap: CS_n high %0d cycles (sclk_while_idle=%0b), need >= %0d", gap, idle_sclk, CS_GAP);
                end
                bits = 0;
                shreg = '0;
                hi_toggle = 1'b0;
                idle_sclk = 1'b0;
            end
            if (spi_sclk_out && !p_sclk) begin
                shreg = {shreg[14:0], spi_sdio_out};
                bits++;
            end
            if (spi_sclk_out && p_sclk && spi_sdio_out !== p_sdio)
                hi_toggle = 1'b1;
            gap = 0;
        end else begin
            gap++;
            if (spi_sclk_out)
                idle_sclk = 1'b1;
            if (p_cs_low) begin
                if (!rst_in)
                    aborts++;
                else begin
                    n_chk++;
                    frames++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL frame: unexpected frame %h (%0d bits)", shreg, bits);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (bits != 16 || shreg !== exp_w || hi_toggle) begin
                            n_fail++;
                            $display("FAIL frame: got %h bits=%0d sdio_toggle_high=%0b, expected %h with 16 bits", shreg, bits, hi_toggle, exp_w);
                        end
                    end
                end
            end
        end
        p_cs_low = !spi_cs_n_out;
        p_sclk   = spi_sclk_out;
        p_sdio   = spi_sdio_out;
    end

    task automatic push_init();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0300);
        exp_q.push_back(16'h0400);
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        n_chk++;
        if ({dac_reset_out, spi_cs_n_out, busy_out, spi_sclk_out, spi_sdio_out, wr_ack_out, init_done_out} !== 7'b1110000) begin
            n_fail++;
            $display("FAIL reset_values: dac,cs_n,busy,sclk,sdio,ack,done = %b, expected 1110000",
                     {dac_reset_out, spi_cs_n_out, busy_out, spi_sclk_out, spi_sdio_out, wr_ack_out, init_done_out});
        end
    endtask

    task automatic test_init();
        int dac_low = 0;
        int done_at = 0;
        int base = frames;
        push_init();
        rst_in = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk_in);
            #1;
            if (dac_low == 0 && !dac_reset_out) dac_low = n;
            if (init_done_out) begin
                done_at = n;
                break;
            end
        end
        n_chk++;
        if (dac_low != RESET_CYCLES) begin
            n_fail++;
            $display("FAIL dac_reset_width: fell after %0d cycles, expected %0d", dac_low, RESET_CYCLES);
        end
        n_chk++;
        if (done_at != INIT_CYC) begin
            n_fail++;
            $display("FAIL init_done_time: rose at cycle %0d, expected %0d", done_at, INIT_CYC);
        end
        n_chk++;
        if (frames - base != 4 || exp_q.size() != 0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL init_frames: %0d frames, %0d pending, busy=%b, expected 4, 0, 0", frames - base, exp_q.size(), busy_out);
        end
    endtask

    task automatic test_host_write(input logic [4:0] a, input logic [7:0] d, input logic [15:0] exp);
        int acks = 0;
        int busy_n = 0;
        logic got = 1'b0;
        logic cs_after = 1'b1;
        wr_addr_in = a;
        wr_data_in = d;
        wr_req_in = 1'b1;
        exp_q.push_back(exp);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_in);
            if (wr_ack_out) acks++;
            if (wr_ack_out && !got) begin
                got = 1'b1;
                @(posedge clk_in);
                #1;
                wr_req_in = 1'b0;
                @(negedge clk_in);
                cs_after = spi_cs_n_out;
                if (busy_out) busy_n++;
            end else if (got) begin
                if (busy_out) busy_n++;
                else break;
            end
        end
        wr_req_in = 1'b0;
        n_chk++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL host_ack_count: %0d ack pulses, expected 1", acks);
        end
        n_chk++;
        if (cs_after !== 1'b0) begin
            n_fail++;
            $display("FAIL host_cs_fall: CS_n=%b the cycle after ack, expected 0", cs_after);
        end
        n_chk++;
        if (busy_n != HOST_BUSY || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL host_busy: busy %0d cycles with %0d pending, expected %0d and 0", busy_n, exp_q.size(), HOST_BUSY);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_req_during_init();
        int early = 0;
        int done_n = 0;
        int ack_n = 0;
        rst_in = 1'b0;
        wr_addr_in = 5'h11;
        wr_data_in = 8'h3C;
        wr_req_in = 1'b1;
        @(posedge clk_in);
        #1;
        exp_q.delete();
        push_init();
        exp_q.push_back(16'h113C);
        rst_in = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk_in);
            if (wr_ack_out && !init_done_out) early++;
            if (init_done_out && done_n == 0) done_n = n;
            if (wr_ack_out) begin
                ack_n = n;
                break;
            end
        end
        @(posedge clk_in);
        #1;
        wr_req_in = 1'b0;
        for (int n = 0; n < 200 && busy_out; n++) begin
            @(posedge clk_in);
            #1;
        end
        n_chk++;
        if (early != 0 || ack_n == 0 || ack_n != done_n) begin
            n_fail++;
            $display("FAIL req_during_init: early_acks=%0d ack_cycle=%0d done_cycle=%0d, expected 0 and ack on done cycle", early, ack_n, done_n);
        end
        n_chk++;
        if (exp_q.size() != 0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL req_during_init_frames: %0d pending, busy=%b, expected 0, 0", exp_q.size(), busy_out);
        end
    endtask

    task automatic test_start_with_req();
        int early = 0;
        int done_at = 0;
        logic ack_first = 1'b0;
        start_in = 1'b1;
        wr_req_in = 1'b1;
        wr_addr_in = 5'h05;
        wr_data_in = 8'h5A;
        @(negedge clk_in);
        n_chk++;
        if (wr_ack_out !== 1'b0) begin
            n_fail++;
            $display("FAIL start_wins_ack: ack=%b with start and request together, expected 0", wr_ack_out);
        end
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        push_init();
        exp_q.push_back(16'h055A);
        n_chk++;
        if (init_done_out !== 1'b0 || dac_reset_out !== 1'b1) begin
            n_fail++;
            $display("FAIL start_restart: init_done=%b dac_reset=%b after start, expected 0 and 1", init_done_out, dac_reset_out);
        end
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk_in);
            #1;
            if (wr_ack_out && !init_done_out) early++;
            if (init_done_out) begin
                done_at = n;
                ack_first = wr_ack_out;
                break;
            end
        end
        @(posedge clk_in);
        #1;
        wr_req_in = 1'b0;
        for (int n = 0; n < 200 && busy_out; n++) begin
            @(posedge clk_in);
            #1;
        end
        n_chk++;
        if (done_at != INIT_CYC || early != 0 || ack_first !== 1'b1) begin
            n_fail++;
            $display("FAIL start_sequence: done at %0d early_acks=%0d ack_on_first_idle=%b, expected %0d, 0, 1", done_at, early, ack_first, INIT_CYC);
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL start_frames: %0d frames pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        int base = frames;
        int base_ab = aborts;
        int done_at = 0;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        exp_q.delete();
        push_init();
        rst_in = 1'b1;
        for (int n = 0; n < 1000 && frames == base; n++) begin
            @(posedge clk_in);
            #1;
        end
        for (int n = 0; n < 100 && spi_cs_n_out; n++) begin
            @(posedge clk_in);
            #1;
        end
        for (int n = 0; n < 100 && !spi_sclk_out; n++) begin
            @(posedge clk_in);
            #1;
        end
        repeat (2 * CLK_DIV * 3) @(posedge clk_in);
        for (int n = 0; n < 100 && !spi_sclk_out; n++) begin
            @(posedge clk_in);
            #1;
        end
        rst_in = 1'b0;
        #1;
        n_chk++;
        if ({spi_cs_n_out, spi_sclk_out, dac_reset_out} !== 3'b101 || frames - base != 1) begin
            n_fail++;
            $display("FAIL midframe_abort: cs_n,sclk,dac_reset=%b after %0d frames, expected 101 after 1", {spi_cs_n_out, spi_sclk_out, dac_reset_out}, frames - base);
        end
        repeat (3) @(posedge clk_in);
        #1;
        exp_q.delete();
        n_chk++;
        if (aborts - base_ab != 1) begin
            n_fail++;
            $display("FAIL midframe_aborted: %0d partial frames seen, expected 1", aborts - base_ab);
        end
        push_init();
        base = frames;
        rst_in = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk_in);
            #1;
            if (init_done_out) begin
                done_at = n;
                break;
            end
        end
        n_chk++;
        if (done_at != INIT_CYC || frames - base != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midframe_restart: done at %0d, %0d frames, %0d pending, expected %0d, 4, 0", done_at, frames - base, exp_q.size(), INIT_CYC);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_host_write(5'h0F, 8'hA5, 16'h0FA5);
        test_host_write(5'h1F, 8'h3C, 16'h1F3C);
        test_req_during_init();
        test_start_with_req();
        test_reset_midframe();
        repeat (4) @(posedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
